// File: rtl/simd_compute_pkg.sv
// Shared types, opcode/function codes and saturation helpers for the SIMD compute array.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package simd_compute_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int OPCODE_BITS   = 4;
    localparam int FUNCTION_BITS = 4;
    localparam int SHIFT_BITS    = $clog2(DATA_WIDTH);

    // Operation classes
    localparam logic [OPCODE_BITS-1:0] OP_ARITH = 4'b0000;
    localparam logic [OPCODE_BITS-1:0] OP_CMP   = 4'b0010;
    localparam logic [OPCODE_BITS-1:0] OP_SHIFT = 4'b0011;

    // Functions within OP_ARITH
    localparam logic [FUNCTION_BITS-1:0] FN_ADD  = 4'b0000;
    localparam logic [FUNCTION_BITS-1:0] FN_SUB  = 4'b0001;
    localparam logic [FUNCTION_BITS-1:0] FN_MUL  = 4'b0010;
    // Functions within OP_CMP
    localparam logic [FUNCTION_BITS-1:0] FN_MAX  = 4'b0000;
    localparam logic [FUNCTION_BITS-1:0] FN_MIN  = 4'b0001;
    localparam logic [FUNCTION_BITS-1:0] FN_EQ   = 4'b0010;
    localparam logic [FUNCTION_BITS-1:0] FN_GT   = 4'b0011;
    // Functions within OP_SHIFT
    localparam logic [FUNCTION_BITS-1:0] FN_ASR  = 4'b0000;
    localparam logic [FUNCTION_BITS-1:0] FN_RELU = 4'b0001;

    // How a reduction beat folds into the per-lane accumulator
    typedef enum logic [1:0] {
        CMB_SUM = 2'd0,
        CMB_MAX = 2'd1,
        CMB_MIN = 2'd2
    } cmb_mode_t;

    typedef logic signed [DATA_WIDTH-1:0]   lane_t;
    typedef logic signed [2*DATA_WIDTH-1:0] wide_t;

    // Clamp a double-width signed value into the lane range
    function automatic lane_t sat_narrow(input wide_t x);
        wide_t max_w;
        wide_t min_w;
        max_w = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        min_w = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
        if (x > max_w)
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (x < min_w)
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return x[DATA_WIDTH-1:0];
    endfunction

    // Signed saturating add of two lane values
    function automatic lane_t sat_add(input lane_t a, input lane_t b);
        wide_t s;
        s = wide_t'(a) + wide_t'(b);
        return sat_narrow(s);
    endfunction

endpackage

// File: rtl/simd_compute_array_if.sv
// Operand/result stream bundle between the operand read path, the compute array and write-back.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready valid-ready handshakes on each side.
interface simd_compute_array_if #(
    parameter int LANES         = 4,
    parameter int DATA_WIDTH    = simd_compute_pkg::DATA_WIDTH,
    parameter int OPCODE_BITS   = simd_compute_pkg::OPCODE_BITS,
    parameter int FUNCTION_BITS = simd_compute_pkg::FUNCTION_BITS,
    parameter int SHIFT_BITS    = simd_compute_pkg::SHIFT_BITS
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic [OPCODE_BITS-1:0]      opcode;
    logic [FUNCTION_BITS-1:0]    fn;
    logic                        acc_en;
    logic [SHIFT_BITS-1:0]       frac_bits;
    logic [LANES*DATA_WIDTH-1:0] data_in0;
    logic [LANES*DATA_WIDTH-1:0] data_in1;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
    logic [LANES*DATA_WIDTH-1:0] data_out;
    logic                        err_illegal;

    // Producer of operand beats and consumer of results
    modport master (
        output in_valid, in_last, opcode, fn, acc_en, frac_bits, data_in0, data_in1, out_ready,
        input  in_ready, out_valid, out_last, data_out, err_illegal
    );

    // The compute array itself
    modport slave (
        input  in_valid, in_last, opcode, fn, acc_en, frac_bits, data_in0, data_in1, out_ready,
        output in_ready, out_valid, out_last, data_out, err_illegal
    );
endinterface

// File: rtl/simd_lane_alu.sv
// One lane's signed saturating operation plus illegal opcode/function decode.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result only when its pipeline advances.
module simd_lane_alu
    import simd_compute_pkg::*;
(
    input  logic [OPCODE_BITS-1:0]   opcode,
    input  logic [FUNCTION_BITS-1:0] fn,
    input  logic [SHIFT_BITS-1:0]    frac_bits,
    input  lane_t                    a,
    input  lane_t                    b,
    output lane_t                    res,
    output cmb_mode_t                cmb,
    output logic                     illegal
);

    wide_t prod;

    // Decode the op, compute the saturated lane result and pick its reduction rule
    always_comb begin
        res     = '0;
        cmb     = CMB_SUM;
        illegal = 1'b0;
        prod    = '0;
        case (opcode)
            OP_ARITH: begin
                case (fn)
                    FN_ADD: res = sat_add(a, b);
                    FN_SUB: res = sat_narrow(wide_t'(a) - wide_t'(b));
                    FN_MUL: begin
                        // Full product cannot overflow 2*DW bits; shift first, clamp last
                        prod = wide_t'(a) * wide_t'(b);
                        res  = sat_narrow(prod >>> frac_bits);
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_CMP: begin
                case (fn)
                    FN_MAX: begin
                        res = (a > b) ? a : b;
                        cmb = CMB_MAX;
                    end
                    FN_MIN: begin
                        res = (a < b) ? a : b;
                        cmb = CMB_MIN;
                    end
                    FN_EQ:   res = (a == b) ? lane_t'(1) : lane_t'(0);
                    FN_GT:   res = (a > b)  ? lane_t'(1) : lane_t'(0);
                    default: illegal = 1'b1;
                endcase
            end
            OP_SHIFT: begin
                case (fn)
                    FN_ASR:  res = a >>> b[SHIFT_BITS-1:0];
                    FN_RELU: res = a[DATA_WIDTH-1] ? lane_t'(0) : a;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/simd_compute_array.sv
// LANES-wide saturating SIMD compute with per-lane streaming reduction (sum/max/min closed by in_last).
// Latency: 2 cycles from acceptance to data_out when not stalled; non-last reduction beats produce no output.
// Backpressure: whole pipeline freezes while out_valid && !out_ready; in_ready = !out_valid || out_ready.
module simd_compute_array
    import simd_compute_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    simd_compute_array_if.slave  io
);

    localparam int DW = DATA_WIDTH;

    logic adv;
    logic accept;

    lane_t           lane_a  [LANES];
    lane_t           lane_b  [LANES];
    lane_t           alu_res [LANES];
    cmb_mode_t       alu_cmb [LANES];
    logic [LANES-1:0] alu_ill;

    // Stage 1: registered raw lane results and beat control
    logic      s1_vld;
    logic      s1_acc;
    logic      s1_last;
    lane_t     s1_res [LANES];
    cmb_mode_t s1_cmb [LANES];

    // Stage 2: output slot and reduction state
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [LANES*DW-1:0]   data_out_q;
    logic                  err_q;
    logic                  acc_first;
    lane_t                 acc_q [LANES];

    lane_t                 comb_val [LANES];
    logic [LANES*DW-1:0]   s1_flat;
    logic [LANES*DW-1:0]   comb_flat;

    assign adv         = !out_valid_q || io.out_ready;
    assign accept      = io.in_valid && adv;
    assign io.in_ready = adv;

    assign io.out_valid   = out_valid_q;
    assign io.out_last    = out_last_q;
    assign io.data_out    = data_out_q;
    assign io.err_illegal = err_q;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign lane_a[g] = io.data_in0[g*DW +: DW];
            assign lane_b[g] = io.data_in1[g*DW +: DW];

            simd_lane_alu u_alu (
                .opcode    (io.opcode),
                .fn        (io.fn),
                .frac_bits (io.frac_bits),
                .a         (lane_a[g]),
                .b         (lane_b[g]),
                .res       (alu_res[g]),
                .cmb       (alu_cmb[g]),
                .illegal   (alu_ill[g])
            );
        end
    endgenerate

    // Stage 1 capture: a bubble is loaded whenever the pipe advances without a valid beat
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_vld  <= 1'b0;
            s1_acc  <= 1'b0;
            s1_last <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_res[i] <= '0;
                s1_cmb[i] <= CMB_SUM;
            end
        end else if (adv) begin
            s1_vld  <= io.in_valid;
            s1_acc  <= io.acc_en;
            s1_last <= io.in_last;
            for (int i = 0; i < LANES; i++) begin
                s1_res[i] <= alu_res[i];
                s1_cmb[i] <= alu_cmb[i];
            end
        end
    end

    // Fold the stage-1 result into the accumulator; each beat carries its own combine rule
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            comb_val[i] = s1_res[i];
            if (!acc_first) begin
                case (s1_cmb[i])
                    CMB_MAX: comb_val[i] = (acc_q[i] > s1_res[i]) ? acc_q[i] : s1_res[i];
                    CMB_MIN: comb_val[i] = (acc_q[i] < s1_res[i]) ? acc_q[i] : s1_res[i];
                    default: comb_val[i] = sat_add(acc_q[i], s1_res[i]);
                endcase
            end
        end
    end

    // Flatten lane arrays onto the output bus layout
    always_comb begin
        s1_flat   = '0;
        comb_flat = '0;
        for (int i = 0; i < LANES; i++) begin
            s1_flat[i*DW +: DW]   = s1_res[i];
            comb_flat[i*DW +: DW] = comb_val[i];
        end
    end

    // Stage 2: plain results and closed reductions fill the output slot; open reductions only update state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            data_out_q  <= '0;
            err_q       <= 1'b0;
            acc_first   <= 1'b1;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else begin
            if (accept && (|alu_ill)) err_q <= 1'b1;
            if (adv) begin
                if (!s1_vld) begin
                    out_valid_q <= 1'b0;
                end else if (!s1_acc) begin
                    out_valid_q <= 1'b1;
                    out_last_q  <= s1_last;
                    data_out_q  <= s1_flat;
                end else if (s1_last) begin
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b1;
                    data_out_q  <= comb_flat;
                    acc_first   <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                    acc_first   <= 1'b0;
                    for (int i = 0; i < LANES; i++) acc_q[i] <= comb_val[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_compute_array.sv
// Directed plus randomized bench for simd_compute_array against a lane-level arithmetic model.
// Latency: checks exact 2-cycle result timing on an idle pipe.
// Backpressure: drives random and directed out_ready stalls; expects held outputs while stalled.
module tb_simd_compute_array;
    import simd_compute_pkg::*;

    localparam int L  = 4;
    localparam int DW = 32;
    localparam int W  = L * DW;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    simd_compute_array_if #(.LANES(L)) io ();

    simd_compute_array #(.LANES(L)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (io)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;
    exp_t sbq[$];

    // Reference model state
    bit     m_first = 1'b1;
    longint m_acc [L];
    bit     m_err = 1'b0;
    int     n_out = 0;

    // Current beat to present
    logic [3:0] b_opc, b_fn;
    bit         b_acc, b_last;
    int         b_frac;
    int         b_a [L];
    int         b_b [L];

    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint x);
        if (x > 64'sd2147483647)  return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    // mode: 0 = sum, 1 = max, 2 = min
    task automatic ref_op(input longint a, input longint b, output longint r,
                          output int mode, output bit ill);
        r = 0; mode = 0; ill = 1'b0;
        if      (b_opc == 4'd0 && b_fn == 4'd0) r = sat(a + b);
        else if (b_opc == 4'd0 && b_fn == 4'd1) r = sat(a - b);
        else if (b_opc == 4'd0 && b_fn == 4'd2) r = sat((a * b) >>> b_frac);
        else if (b_opc == 4'd2 && b_fn == 4'd0) begin r = (a > b) ? a : b; mode = 1; end
        else if (b_opc == 4'd2 && b_fn == 4'd1) begin r = (a < b) ? a : b; mode = 2; end
        else if (b_opc == 4'd2 && b_fn == 4'd2) r = (a == b) ? 1 : 0;
        else if (b_opc == 4'd2 && b_fn == 4'd3) r = (a > b) ? 1 : 0;
        else if (b_opc == 4'd3 && b_fn == 4'd0) r = a >>> (b & 31);
        else if (b_opc == 4'd3 && b_fn == 4'd1) r = (a < 0) ? 0 : a;
        else ill = 1'b1;
    endtask

    function automatic logic [W-1:0] pack_l(input longint r [L]);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < L; i++) p[i*DW +: DW] = r[i][DW-1:0];
        return p;
    endfunction

    function automatic logic [W-1:0] pack_i(input int r [L]);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < L; i++) p[i*DW +: DW] = r[i];
        return p;
    endfunction

    // Apply one accepted beat to the model
    task automatic model_accept();
        longint r [L];
        longint v [L];
        int     mode;
        bit     ill;
        exp_t   e;
        for (int i = 0; i < L; i++) begin
            ref_op(longint'(b_a[i]), longint'(b_b[i]), r[i], mode, ill);
            if (ill) m_err = 1'b1;
            if (m_first)        v[i] = r[i];
            else if (mode == 1) v[i] = (m_acc[i] > r[i]) ? m_acc[i] : r[i];
            else if (mode == 2) v[i] = (m_acc[i] < r[i]) ? m_acc[i] : r[i];
            else                v[i] = sat(m_acc[i] + r[i]);
        end
        if (!b_acc) begin
            e.data = pack_l(r); e.last = b_last; sbq.push_back(e);
        end else if (b_last) begin
            e.data = pack_l(v); e.last = 1'b1; sbq.push_back(e);
            m_first = 1'b1;
        end else begin
            for (int i = 0; i < L; i++) m_acc[i] = v[i];
            m_first = 1'b0;
        end
    endtask

    task automatic pop_check();
        exp_t e;
        tests++;
        assert (sbq.size() > 0) else begin
            fails++;
            $error("FAIL sb_extra: observed output %h expected no output", io.data_out);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chkw("sb_data", io.data_out, e.data);
            chk1("sb_last", io.out_last, e.last);
        end
        n_out++;
    endtask

    // One clock: sample at negedge, drive, settle, then step through the rising edge
    task automatic cycle(input bit v, input bit ordy);
        bit accepted;
        if (prev_stall) begin
            chk1("hold_valid", io.out_valid, 1'b1);
            chkw("hold_data", io.data_out, prev_data);
            chk1("hold_last", io.out_last, prev_last);
        end
        chk1("err_illegal", io.err_illegal, m_err);
        io.in_valid  = v;
        io.opcode    = b_opc;
        io.fn        = b_fn;
        io.acc_en    = b_acc;
        io.in_last   = b_last;
        io.frac_bits = b_frac[SHIFT_BITS-1:0];
        io.data_in0  = pack_i(b_a);
        io.data_in1  = pack_i(b_b);
        io.out_ready = ordy;
        #1;
        chk1("in_ready", io.in_ready, !io.out_valid || ordy);
        if (io.out_valid && ordy) pop_check();
        prev_stall = io.out_valid && !ordy;
        prev_data  = io.data_out;
        prev_last  = io.out_last;
        accepted   = v && io.in_ready && reset_n;
        if (accepted) model_accept();
        @(posedge clk);
        if (!reset_n) begin
            sbq.delete();
            m_first    = 1'b1;
            m_err      = 1'b0;
            prev_stall = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_beat(input logic [3:0] opc, input logic [3:0] fn,
                            input bit acc, input bit last, input int frac);
        b_opc = opc; b_fn = fn; b_acc = acc; b_last = last; b_frac = frac;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int k = 0; k < n; k++) cycle(1'b0, ordy);
    endtask

    function automatic int rnd_val();
        case ($urandom % 4)
            0:       return int'($urandom_range(0, 40)) - 20;
            1:       return int'($urandom);
            2:       return int'(32'h7FFF_FFFF - ($urandom % 4));
            default: return int'(32'h8000_0000 + ($urandom % 4));
        endcase
    endfunction

    logic [3:0] op_tbl [11] = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd5, 4'd0};
    logic [3:0] fn_tbl [11] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd0, 4'd7};

    initial begin
        int n0;
        int idx;

        // Reset / idle
        reset_n = 1'b0;
        set_beat(4'd0, 4'd0, 1'b0, 1'b0, 0);
        b_a = '{0, 0, 0, 0}; b_b = '{0, 0, 0, 0};
        io.in_valid = 1'b0; io.in_last = 1'b0; io.opcode = '0; io.fn = '0; io.acc_en = 1'b0;
        io.frac_bits = '0; io.data_in0 = '0; io.data_in1 = '0; io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk1("rst_out_valid", io.out_valid, 1'b0);
        chk1("rst_out_last", io.out_last, 1'b0);
        chkw("rst_data_out", io.data_out, '0);
        chk1("rst_err", io.err_illegal, 1'b0);
        chk1("rst_in_ready", io.in_ready, 1'b1);

        // ADD saturation and exact 2-cycle latency
        set_beat(4'd0, 4'd0, 1'b0, 1'b0, 0);
        b_a = '{32'h7FFF_FFF0, -5, 100, -100};
        b_b = '{32'h0000_0020,  3,   7,   -1};
        cycle(1'b1, 1'b1);
        chk1("add_lat1_valid", io.out_valid, 1'b0);
        idle(1, 1'b1);
        chk1("add_lat2_valid", io.out_valid, 1'b1);
        chk32("add_lane0", io.data_out[31:0], 32'h7FFF_FFFF);
        chk32("add_lane1", io.data_out[63:32], 32'hFFFF_FFFE);
        chk1("add_last", io.out_last, 1'b0);
        idle(1, 1'b1);

        // Q16 multiply: 1.5 * -2.0 = -3.0
        set_beat(4'd0, 4'd2, 1'b0, 1'b1, 16);
        b_a = '{32'h0001_8000, 32'h0001_0000, 0, 32'h7FFF_FFFF};
        b_b = '{32'hFFFE_0000, 32'h0001_0000, 5, 32'h7FFF_FFFF};
        cycle(1'b1, 1'b1);
        idle(1, 1'b1);
        chk32("mul_lane0", io.data_out[31:0], 32'hFFFD_0000);
        chk32("mul_lane3_sat", io.data_out[127:96], 32'h7FFF_FFFF);
        idle(1, 1'b1);

        // Dot product over 4 beats
        n0 = n_out;
        for (int k = 0; k < 4; k++) begin
            set_beat(4'd0, 4'd2, 1'b1, (k == 3), 0);
            b_a = '{2*k + 1, k, -k, 1000};
            b_b = '{2*k + 2, 1, k, -3};
            cycle(1'b1, 1'b1);
        end
        idle(1, 1'b1);
        chk32("dot_lane0", io.data_out[31:0], 32'd100);
        chk1("dot_last", io.out_last, 1'b1);
        idle(2, 1'b1);
        chk32("dot_out_count", 32'(n_out - n0), 32'd1);

        // MAX reduction over 3 beats
        begin
            int ma [3] = '{-7, 3, 2};
            int mb [3] = '{-7, -1, 2};
            for (int k = 0; k < 3; k++) begin
                set_beat(4'd2, 4'd0, 1'b1, (k == 2), 0);
                b_a = '{ma[k], k, 0, -k};
                b_b = '{mb[k], 0, 0, 5};
                cycle(1'b1, 1'b1);
            end
        end
        idle(1, 1'b1);
        chk32("max_lane0", io.data_out[31:0], 32'd3);
        idle(2, 1'b1);

        // Backpressure: two beats enter, then 5 stalled cycles with a beat offered
        set_beat(4'd0, 4'd1, 1'b0, 1'b0, 0);
        b_a = '{10, 20, 30, 40}; b_b = '{1, 2, 3, 4};
        cycle(1'b1, 1'b0);
        b_a = '{50, 60, 70, 80};
        cycle(1'b1, 1'b0);
        b_a = '{90, 91, 92, 93};
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0);
            chk1("bp_in_ready", io.in_ready, 1'b0);
        end
        cycle(1'b1, 1'b1);
        idle(4, 1'b1);
        chk32("bp_drained", 32'(sbq.size()), 32'd0);

        // Illegal op: zero result, sticky flag until reset
        set_beat(4'd5, 4'd0, 1'b0, 1'b0, 0);
        b_a = '{1, 2, 3, 4}; b_b = '{5, 6, 7, 8};
        cycle(1'b1, 1'b1);
        idle(1, 1'b1);
        chkw("ill_data", io.data_out, '0);
        chk1("ill_err", io.err_illegal, 1'b1);
        set_beat(4'd0, 4'd0, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        idle(3, 1'b1);
        chk1("ill_err_sticky", io.err_illegal, 1'b1);

        // Partial group, then reset: the group must be discarded
        set_beat(4'd0, 4'd0, 1'b1, 1'b0, 0);
        b_a = '{500, 500, 500, 500}; b_b = '{1, 1, 1, 1};
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        idle(2, 1'b1);
        reset_n = 1'b0;
        idle(2, 1'b1);
        reset_n = 1'b1;
        chk1("rst2_err", io.err_illegal, 1'b0);
        chk1("rst2_valid", io.out_valid, 1'b0);
        set_beat(4'd0, 4'd0, 1'b1, 1'b1, 0);
        b_a = '{7, -7, 0, 1}; b_b = '{1, 1, 0, 1};
        cycle(1'b1, 1'b1);
        idle(1, 1'b1);
        chk32("single_grp_lane0", io.data_out[31:0], 32'd8);
        chk1("single_grp_last", io.out_last, 1'b1);
        idle(1, 1'b1);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 600; n++) begin
            idx = ($urandom % 25 == 0) ? 9 + int'($urandom % 2) : int'($urandom % 9);
            set_beat(op_tbl[idx], fn_tbl[idx], ($urandom % 2) == 1, ($urandom % 3) == 0,
                     int'($urandom % 32));
            for (int i = 0; i < L; i++) begin
                b_a[i] = rnd_val();
                b_b[i] = rnd_val();
            end
            cycle(($urandom % 4) != 0, ($urandom % 4) != 0);
        end
        set_beat(4'd0, 4'd0, 1'b0, 1'b0, 0);
        idle(10, 1'b1);
        chk32("final_sb_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
